i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Single-master I2C controller that drives the bus upstream of the on-board I2C slave register block (device address 7'h57).
- Converts a one-cycle command into a complete single-byte register write or register read transaction on open-drain scl/sda.
- Returns read data, completion and acknowledge status to the local host logic.

Parameters:
CLK_DIV, 125, system clocks per SCL quarter-period (SCL = f_clk/(4*CLK_DIV); 100 kHz at 50 MHz); legal range 2..65535
DEV_ADDR, 7'h57, 7-bit target device address

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  command strobe; sampled only when busy=0
rw  input  1  0 = register write, 1 = register read; captured with start
reg_addr  input  8  target register address; captured with start
wr_data  input  8  write byte; captured with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at end of transaction
ack_err  output  1  NACK seen in the last transaction; valid with done, held until next accepted start
rd_data  output  8  byte read; updated only on successful read completion
scl  inout  1  open-drain: driven 0 or released (z)
sda  inout  1  open-drain: driven 0 or released (z)

Behaviour:
- Reset (synchronous, active-high, same-edge effect): FSM to IDLE; scl/sda released; busy=0, done=0, ack_err=0, rd_data=8'h00; quarter and bit counters cleared. Reset mid-transaction abandons the bus immediately, with no STOP issued.
- Timing base: a divider counts 0..CLK_DIV-1 to produce one tick per quarter. A 2-bit phase counts q0..q3 per bit.
  - Data bit: SCL low in q0-q1 and high in q2-q3.
  - SDA changes only at entry to q0.
  - SDA is sampled on the last clk of q2.
- Command accept: start=1 while busy=0 captures rw, reg_addr and wr_data; busy rises next cycle. start while busy=1 is ignored with no side effects.
- States:
  - IDLE
  - START: SDA released in q0-q1, SDA low in q2-q3 with SCL high, then SCL low.
  - ADDR: 8 bits, {DEV_ADDR,0}, MSB first.
  - ADDR_ACK
  - REG: reg_addr.
  - REG_ACK
  - Write path: WDAT (wr_data), then WDAT_ACK.
  - Read path: RSTART, then RADDR ({DEV_ADDR,1}), then RADDR_ACK, then RDAT (8 bits shifted in), then RNACK (master releases SDA = NACK).
  - STOP: q0 SCL low/SDA low, q1-q2 SCL high/SDA low, q3 SDA released.
- Sequence: REG_ACK goes to WDAT when rw=0, and to RSTART when rw=1. RSTART is the same waveform as START, but begins with SCL low and SDA released.
- Bit counter: 0..7 per byte. It is cleared on entering each byte state. Every ACK/NACK slot is exactly one bit time.
- ACK slots: SDA released.
  - Sampled 0: continue.
  - Sampled 1: set ack_err and go to STOP, skipping remaining bytes; rd_data is unchanged.
- Completion: done pulses for one cycle after the final STOP quarter. busy falls in the same cycle. FSM returns to IDLE. A new start is accepted in that cycle or later.
- Read capture: rd_data is loaded from the shift register when RNACK completes.
- Transaction length, excluding the accept cycle:
  - Write: 116*CLK_DIV clocks (START 4q + 3×9 bits×4q + STOP 4q).
  - Read: 156*CLK_DIV clocks.
- While idle, both lines are released at all times.

Optional Feature:
I2CM_CLK_STRETCH_EN
- Defined: at entry to q2, the master releases SCL and holds the divider and phase until the synchronized scl input (2-flop synchronizer) reads 1. The q2 length then counts from the observed rise.
- Undefined: scl input is ignored and timing is purely divider-based. No synchronizer flops are instantiated for scl.

Test Plan:
- Write, CLK_DIV=4, rw=0, reg_addr=8'h01, wr_data=8'hA5, connected to slave block -> exactly 464 clks to done; ack_err=0; slave register 1 = 8'hA5.
- Write reg_addr=8'h00, wr_data=8'h3C -> slave reg0dat=4'hC; SDA never changes while SCL high except at START/STOP.
- Read rw=1, reg_addr=8'h01 after the 8'hA5 write -> repeated START seen; rd_data=8'hA5; ack_err=0; 624 clks to done.
- DEV_ADDR=7'h22 against slave at 7'h57 -> NACK in ADDR_ACK; STOP issued; done with ack_err=1; rd_data holds previous value; slave registers unchanged.
- start pulsed mid-transaction with different reg_addr -> ignored; completed transaction uses the original captured values.
- rst asserted during REG byte -> next cycle scl/sda released, busy=0; a following write of 8'h5A to reg 2 completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C register write/read master with open-drain scl/sda.
// Define I2CM_CLK_STRETCH_EN to honour slave clock stretching in q2.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h57
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  inout  wire        scl,
  inout  wire        sda
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK,
    S_REG, S_REG_ACK, S_WDAT, S_WDAT_ACK,
    S_RSTART, S_RADDR, S_RADDR_ACK, S_RDAT,
    S_RNACK, S_STOP
  } state_e;

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        samp_q, samp_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        scl_lo_q, scl_lo_d;
  logic        sda_lo_q, sda_lo_d;

  logic hold;
  logic tick;
  logic last;
  logic sda_in;

  assign sda_in = sda;

`ifdef I2CM_CLK_STRETCH_EN
  logic [1:0] scl_sync_q;
  logic       rise_q, rise_d;

  // q2 is held until the released SCL is actually seen high
  assign hold = (state_q != S_IDLE) && (phase_q == 2'd2) && !rise_q;

  always_comb begin
    rise_d = rise_q;
    if (tick) begin
      rise_d = 1'b0;
    end else if (phase_q == 2'd2 && scl_sync_q[1]) begin
      rise_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b00;
      rise_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      rise_q     <= rise_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  assign tick = !hold && (div_q == DIV_MAX);
  assign last = tick && (phase_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    samp_d    = samp_q;
    rw_d      = rw_q;
    reg_d     = reg_q;
    wdat_d    = wdat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    if (state_q == S_IDLE) begin
      div_d   = '0;
      phase_d = '0;
      if (start) begin
        rw_d      = rw;
        reg_d     = reg_addr;
        wdat_d    = wr_data;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        state_d   = S_START;
      end
    end else begin
      if (tick) begin
        div_d   = '0;
        phase_d = phase_q + 2'd1;
      end else if (!hold) begin
        div_d = div_q + 16'd1;
      end
      if (tick && phase_q == 2'd2) begin
        samp_d = sda_in;
        if (state_q == S_RDAT) rx_d = {rx_q[6:0], sda_in};
      end
      if (last) begin
        case (state_q)
          S_START: begin
            state_d = S_ADDR;
            bit_d   = '0;
            tx_d    = {DEV_ADDR, 1'b0};
          end
          S_RSTART: begin
            state_d = S_RADDR;
            bit_d   = '0;
            tx_d    = {DEV_ADDR, 1'b1};
          end
          S_ADDR, S_REG, S_WDAT, S_RADDR, S_RDAT: begin
            if (bit_q == 3'd7) begin
              unique case (1'b1)
                state_q == S_ADDR:  state_d = S_ADDR_ACK;
                state_q == S_REG:   state_d = S_REG_ACK;
                state_q == S_WDAT:  state_d = S_WDAT_ACK;
                state_q == S_RADDR: state_d = S_RADDR_ACK;
                default:            state_d = S_RNACK;
              endcase
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end
          S_ADDR_ACK, S_REG_ACK, S_WDAT_ACK, S_RADDR_ACK: begin
            bit_d = '0;
            if (samp_q) begin
              ack_err_d = 1'b1;
              state_d   = S_STOP;
            end else begin
              unique case (1'b1)
                state_q == S_ADDR_ACK: begin
                  state_d = S_REG;
                  tx_d    = reg_q;
                end
                state_q == S_REG_ACK: begin
                  state_d = rw_q ? S_RSTART : S_WDAT;
                  tx_d    = wdat_q;
                end
                state_q == S_RADDR_ACK: state_d = S_RDAT;
                default:                state_d = S_STOP;
              endcase
            end
          end
          S_RNACK: begin
            rd_data_d = rx_q;
            state_d   = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Line drive follows the next state so it changes with the quarter
  always_comb begin
    scl_lo_d = 1'b0;
    sda_lo_d = 1'b0;
    case (state_d)
      S_START: sda_lo_d = phase_d[1];
      S_RSTART: begin
        scl_lo_d = (phase_d == 2'd0);
        sda_lo_d = phase_d[1];
      end
      S_ADDR, S_REG, S_WDAT, S_RADDR: begin
        scl_lo_d = !phase_d[1];
        sda_lo_d = !tx_d[7];
      end
      S_ADDR_ACK, S_REG_ACK, S_WDAT_ACK,
      S_RADDR_ACK, S_RDAT, S_RNACK: begin
        scl_lo_d = !phase_d[1];
      end
      S_STOP: begin
        scl_lo_d = (phase_d == 2'd0);
        sda_lo_d = (phase_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      samp_q    <= 1'b0;
      rw_q      <= 1'b0;
      reg_q     <= '0;
      wdat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= '0;
      scl_lo_q  <= 1'b0;
      sda_lo_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      samp_q    <= samp_d;
      rw_q      <= rw_d;
      reg_q     <= reg_d;
      wdat_q    <= wdat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      scl_lo_q  <= scl_lo_d;
      sda_lo_q  <= sda_lo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;
  assign scl     = scl_lo_q ? 1'b0 : 1'bz;
  assign sda     = sda_lo_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: two masters share a bus with a
// behavioural register slave at 7'h57.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy_a, done_a, ack_err_a;
  logic       busy_b, done_b, ack_err_b;
  logic [7:0] rd_data_a, rd_data_b;
  wire        scl;
  wire        sda;

  pullup (scl);
  pullup (sda);

  i2c_master_ctrl #(.CLK_DIV(4), .DEV_ADDR(7'h57)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw),
    .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy_a), .done(done_a), .ack_err(ack_err_a),
    .rd_data(rd_data_a), .scl(scl), .sda(sda)
  );

  i2c_master_ctrl #(.CLK_DIV(4), .DEV_ADDR(7'h22)) u_bad (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw),
    .reg_addr(reg_addr), .wr_data(wr_data),
    .busy(busy_b), .done(done_b), .ack_err(ack_err_b),
    .rd_data(rd_data_b), .scl(scl), .sda(sda)
  );

  initial forever #5 clk = ~clk;

  localparam int M_IDLE = 0, M_ADDR = 1, M_REG = 2, M_WDATA = 3;
  localparam int M_TXA = 4, M_TX = 5, M_IGN = 6;

  logic       s_low = 1'b0;
  logic [7:0] regs [0:3] = '{default: 8'h00};
  int         n_st = 0;
  int         n_sp = 0;

  assign sda = s_low ? 1'b0 : 1'bz;

  // Slave plus bus monitor: any SDA edge while SCL stays high is
  // counted as START (fall) or STOP (rise).
  initial begin
    logic       scl_p, sda_p, sc, sd;
    logic [7:0] sh, tx, ptr;
    int         mode, cnt;
    scl_p = 1'b1; sda_p = 1'b1;
    sh = '0; tx = '0; ptr = '0;
    mode = M_IDLE; cnt = 0;
    forever begin
      @(negedge clk);
      sc = (scl !== 1'b0);
      sd = (sda !== 1'b0);
      if (scl_p && sc && sda_p && !sd) begin
        n_st++;
        mode = M_ADDR; cnt = -1; s_low = 1'b0;
      end else if (scl_p && sc && !sda_p && sd) begin
        n_sp++;
        mode = M_IDLE; s_low = 1'b0;
      end else if (!scl_p && sc) begin
        if ((mode == M_ADDR || mode == M_REG || mode == M_WDATA)
            && cnt >= 0 && cnt < 8)
          sh = {sh[6:0], sd};
      end else if (scl_p && !sc && mode != M_IDLE) begin
        cnt++;
        if (cnt == 9) cnt = 0;
        s_low = 1'b0;
        if (cnt == 8) begin
          case (mode)
            M_ADDR: begin
              if (sh[7:1] == 7'h57) begin
                s_low = 1'b1;
                mode = sh[0] ? M_TXA : M_REG;
              end else begin
                mode = M_IGN;
              end
            end
            M_REG: begin
              ptr = sh; s_low = 1'b1; mode = M_WDATA;
            end
            M_WDATA: begin
              if (ptr == 8'h00) regs[0] = {4'h0, sh[3:0]};
              else regs[ptr[1:0]] = sh;
              s_low = 1'b1;
            end
            default: ;
          endcase
        end else if (cnt == 0 && mode == M_TXA) begin
          mode = M_TX; tx = regs[ptr[1:0]]; s_low = !tx[7];
        end else if (cnt == 0 && mode == M_TX) begin
          mode = M_IGN;
        end else if (mode == M_TX && cnt >= 1 && cnt <= 7) begin
          s_low = !tx[7-cnt];
        end
      end
      scl_p = sc; sda_p = sd;
    end
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic busy_seen;

  // Issues one command; returns clocks from accept edge to done.
  task automatic run(input bit use_b, input bit r, input logic [7:0] a,
                     input logic [7:0] d, input int glitch_at,
                     input int rst_at, output int cyc);
    @(negedge clk);
    rw = r; reg_addr = a; wr_data = d;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0;
    busy_seen = use_b ? busy_b : busy_a;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_at != 0 && cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (glitch_at != 0 && cyc == glitch_at) begin
        start_a = 1'b1; rw = ~r; reg_addr = 8'h03; wr_data = 8'h77;
      end
      if (glitch_at != 0 && cyc == glitch_at + 1) begin
        start_a = 1'b0; rw = r; reg_addr = a; wr_data = d;
      end
      if ((use_b ? done_b : done_a) === 1'b1) break;
    end
  endtask

  initial begin
    int cyc, st0, sp0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ack_err", ack_err_a, 1'b0);
    chk("rst_rd_data", rd_data_a, 8'h00);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("idle_lines", {scl, sda}, 2'b11);

    st0 = n_st; sp0 = n_sp;
    run(1'b0, 1'b0, 8'h01, 8'hA5, 0, 0, cyc);
    chk("wr1_cycles", cyc, 464);
    chk("wr1_busy_during", busy_seen, 1'b1);
    chk("wr1_busy_end", busy_a, 1'b0);
    chk("wr1_ack_err", ack_err_a, 1'b0);
    chk("wr1_reg1", regs[1], 8'hA5);
    chk("wr1_starts", n_st - st0, 1);
    chk("wr1_stops", n_sp - sp0, 1);
    @(posedge clk);
    #1 chk("wr1_done_pulse", done_a, 1'b0);

    st0 = n_st; sp0 = n_sp;
    run(1'b0, 1'b0, 8'h00, 8'h3C, 0, 0, cyc);
    chk("wr0_cycles", cyc, 464);
    chk("wr0_reg0", regs[0][3:0], 4'hC);
    chk("wr0_ack_err", ack_err_a, 1'b0);
    chk("wr0_starts", n_st - st0, 1);
    chk("wr0_stops", n_sp - sp0, 1);

    st0 = n_st; sp0 = n_sp;
    run(1'b0, 1'b1, 8'h01, 8'h00, 0, 0, cyc);
    chk("rd_cycles", cyc, 624);
    chk("rd_data", rd_data_a, 8'hA5);
    chk("rd_ack_err", ack_err_a, 1'b0);
    chk("rd_starts", n_st - st0, 2);
    chk("rd_stops", n_sp - sp0, 1);

    st0 = n_st; sp0 = n_sp;
    run(1'b1, 1'b1, 8'h01, 8'h00, 0, 0, cyc);
    chk("nack_cycles", cyc, 176);
    chk("nack_ack_err", ack_err_b, 1'b1);
    chk("nack_rd_data", rd_data_b, 8'h00);
    chk("nack_starts", n_st - st0, 1);
    chk("nack_stops", n_sp - sp0, 1);
    chk("nack_reg1", regs[1], 8'hA5);
    chk("nack_reg0", regs[0], 8'h0C);
    repeat (10) @(posedge clk);
    #1 chk("nack_err_held", ack_err_b, 1'b1);
    chk("nack_main_rd", rd_data_a, 8'hA5);

    st0 = n_st;
    run(1'b0, 1'b0, 8'h02, 8'h11, 50, 0, cyc);
    chk("glitch_cycles", cyc, 464);
    chk("glitch_reg2", regs[2], 8'h11);
    chk("glitch_reg3", regs[3], 8'h00);
    chk("glitch_starts", n_st - st0, 1);
    repeat (3) @(posedge clk);
    #1 chk("glitch_idle", busy_a, 1'b0);

    run(1'b0, 1'b0, 8'h03, 8'h99, 0, 180, cyc);
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_scl", scl, 1'b1);
    chk("rst_mid_sda", sda, 1'b1);
    chk("rst_mid_done", done_a, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    run(1'b0, 1'b0, 8'h02, 8'h5A, 0, 0, cyc);
    chk("post_rst_cycles", cyc, 464);
    chk("post_rst_ack_err", ack_err_a, 1'b0);
    chk("post_rst_reg2", regs[2], 8'h5A);
    chk("post_rst_reg3", regs[3], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
